spi_tx_arb: RTL and testbench
=============================

SPI_TX_ARB -- requirements
Module: spi_tx_arb

Interface
REQ-001 SHALL have parameter BUSY_TO, default 64: maximum number of cycles to wait for spi_busy to rise after tx_en.
REQ-002 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-003 SHALL have port rstn, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have ports req0_valid / req1_valid, input, 1: requester has a byte offered.
REQ-005 SHALL have ports req0_data / req1_data, input, 8: byte to transmit.
REQ-006 SHALL have ports req0_last / req1_last, input, 1: offered byte ends the requester's burst.
REQ-007 SHALL have ports req0_ready / req1_ready, output, 1: byte accepted when valid && ready.
REQ-008 SHALL have port tx_data, output, 8: byte to the SPI master.
REQ-009 SHALL have port tx_en, output, 1: one-cycle start pulse to the SPI master.
REQ-010 SHALL have port spi_busy, input, 1: SPI master transfer in progress.
REQ-011 SHALL have port grant, output, 2: one-hot owner of the SPI master; 2'b00 when idle.
REQ-012 SHALL have port err_timeout, output, 1: one-cycle pulse when spi_busy fails to rise within BUSY_TO cycles.

Function
REQ-013 SHALL implement the FSM states IDLE, SEND, WAIT_BUSY, WAIT_DONE and NEXT.
REQ-014 IDLE: when spi_busy=0 and any valid, SHALL pick a winner, assert its ready combinationally in the same cycle, capture its data and last, set grant, and go to SEND.
REQ-015 In IDLE with spi_busy=1, SHALL assert no ready and stay in IDLE.
REQ-016 Arbitration SHALL be round-robin with priority pointer prio: a single valid wins outright; if both are valid, req[prio] wins.
REQ-017 prio SHALL be set to the other requester when a burst ends, whether by last or by timeout.
REQ-018 SEND: SHALL drive tx_en=1 for exactly one cycle with tx_data = captured byte, then go to WAIT_BUSY.
REQ-019 tx_data SHALL hold its value from SEND until the next capture.
REQ-020 WAIT_BUSY: on spi_busy=1, SHALL go to WAIT_DONE.
REQ-021 WAIT_BUSY timeout: the counter SHALL start at 0 on entry and increment each cycle; when it equals BUSY_TO-1 with spi_busy=0, SHALL pulse err_timeout, clear grant, rotate prio and go to IDLE, discarding the rest of the burst.
REQ-022 WAIT_DONE: on spi_busy=0, SHALL go to IDLE (clearing grant and rotating prio) if the captured last=1, else go to NEXT.
REQ-023 NEXT: SHALL assert ready only for the granted requester while it is valid, capture the byte and go to SEND; the burst is locked, so the other requester is never served mid-burst.
REQ-024 With a single byte in flight, back-to-back bytes of one burst SHALL have a minimum of 1 cycle between spi_busy falling and the next tx_en.
REQ-025 ready SHALL be 0 in SEND, WAIT_BUSY and WAIT_DONE.
REQ-026 grant SHALL be stable from capture through burst end.
REQ-027 The timeout counter SHALL be $clog2(BUSY_TO+1) bits wide and saturate-free (it is cleared on every WAIT_BUSY entry).

Reset
REQ-028 While rstn=0, SHALL force state=IDLE, prio=0, grant=2'b00, tx_en=0, tx_data=8'h00, ready=0, err_timeout=0, counter=0, regardless of clk.
REQ-029 Reset asserted mid-burst SHALL abandon the burst; no tx_en shall be issued after release until a new capture occurs.

Structure
REQ-030 The state enum, the grant encodings and the BUSY_TO default SHALL live in shared package spi_pkg.
REQ-031 Arbitration SHALL be isolated in sub-module spi_rr_arb2, which takes the valid bits and prio and produces a one-hot winner combinationally.
REQ-032 Target size SHALL be 150-250 lines of RTL.

Verification
REQ-033 Single byte: req0 sends 8'h01 with last=1 -> ready0 pulses once, tx_en pulses once with tx_data=8'h01, grant=01 until spi_busy falls, then 00.
REQ-034 Contention: both valid at reset release (prio=0) -> req0 is served first, then req1; on a second contention req1 is served first.
REQ-035 Burst lock: req0 sends 3 bytes (8'hA1, 8'hA2, 8'hA3 with last on the third) while req1 is held valid -> three tx_en pulses with data A1, A2, A3 in order, with req1_ready=0 throughout, then req1 is granted.
REQ-036 Timeout: spi_busy is held at 0 after tx_en, with BUSY_TO=64 -> err_timeout pulses exactly 64 cycles after entering WAIT_BUSY, grant returns to 00, and prio flips.
REQ-037 External busy: spi_busy=1 while in IDLE with req1 valid -> no ready and no tx_en until spi_busy drops.
REQ-038 Reset mid-burst: rstn is pulsed low during WAIT_DONE of byte 2 of 3 -> all outputs return to their reset values immediately, and no further tx_en occurs while valid is deasserted.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the two-requester SPI transmit arbiter.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_BUSY,
    WAIT_DONE,
    NEXT
  } state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_REQ0 = 2'b01;
  localparam logic [1:0] GRANT_REQ1 = 2'b10;

  localparam int BUSY_TO_DEF = 64;

  // Priority goes to the requester that did not own the finished burst.
  function automatic logic prio_after(input logic [1:0] owner);
    return owner[0];
  endfunction

endpackage

// File: rtl/spi_tx_arb_if.sv
// Requester handshakes and SPI master control bundled for the arbiter.
interface spi_tx_arb_if;
  // A byte moves on a rising clk edge where reqN_valid && reqN_ready; a
  // requester keeps valid/data/last stable until that edge, and ready is
  // a combinational function of state and valid.
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_last;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_last;
  logic       req1_ready;
  logic [7:0] tx_data;
  logic       tx_en;
  logic       spi_busy;
  logic [1:0] grant;
  logic       err_timeout;

  modport slave (
    input  req0_valid, req0_data, req0_last,
    input  req1_valid, req1_data, req1_last,
    input  spi_busy,
    output req0_ready, req1_ready,
    output tx_data, tx_en, grant, err_timeout
  );

  modport master (
    output req0_valid, req0_data, req0_last,
    output req1_valid, req1_data, req1_last,
    output spi_busy,
    input  req0_ready, req1_ready,
    input  tx_data, tx_en, grant, err_timeout
  );
endinterface

// File: rtl/spi_rr_arb2.sv
// Two-way round-robin pick: a lone valid wins, a tie goes to prio.
module spi_rr_arb2
  import spi_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       prio,
  output logic [1:0] winner
);

  always_comb begin
    winner = valid;
    if (valid == 2'b11) begin
      winner = prio ? GRANT_REQ1 : GRANT_REQ0;
    end
  end

endmodule

// File: rtl/spi_tx_arb.sv
// Shares one SPI master between two byte requesters, locking the master
// to one requester for a whole burst and timing out a silent master.
module spi_tx_arb
  import spi_pkg::*;
#(
  parameter int BUSY_TO = BUSY_TO_DEF
) (
  input  logic         clk,
  input  logic         rstn,
  spi_tx_arb_if.slave  bus,
  output state_t       state_dbg
);

  localparam int CW = $clog2(BUSY_TO + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BUSY_TO - 1);

  state_t        state_q, state_d;
  logic          prio_q, prio_d;
  logic [1:0]    grant_q, grant_d;
  logic [7:0]    data_q, data_d;
  logic          last_q, last_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    valid, win, ready;

  assign valid = {bus.req1_valid, bus.req0_valid};

  spi_rr_arb2 u_arb (
    .valid  (valid),
    .prio   (prio_q),
    .winner (win)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      grant_q <= GRANT_NONE;
      data_q  <= 8'h00;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      last_q  <= last_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    grant_d = grant_q;
    data_d  = data_q;
    last_d  = last_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    ready   = 2'b00;
    case (state_q)
      IDLE: begin
        if (!bus.spi_busy && (valid != 2'b00)) begin
          ready   = win;
          grant_d = win;
          data_d  = win[1] ? bus.req1_data : bus.req0_data;
          last_d  = win[1] ? bus.req1_last : bus.req0_last;
          state_d = SEND;
        end
      end
      SEND: begin
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.spi_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CNT_LAST) begin
          // The rest of the burst is dropped; the owner must start over.
          err_d   = 1'b1;
          grant_d = GRANT_NONE;
          prio_d  = prio_after(grant_q);
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!bus.spi_busy) begin
          if (last_q) begin
            grant_d = GRANT_NONE;
            prio_d  = prio_after(grant_q);
            state_d = IDLE;
          end else begin
            state_d = NEXT;
          end
        end
      end
      NEXT: begin
        ready = grant_q & valid;
        if ((grant_q & valid) != 2'b00) begin
          data_d  = grant_q[1] ? bus.req1_data : bus.req0_data;
          last_d  = grant_q[1] ? bus.req1_last : bus.req0_last;
          state_d = SEND;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ready is combinational, so it is also gated by reset directly.
  assign bus.req0_ready  = ready[0] & rstn;
  assign bus.req1_ready  = ready[1] & rstn;
  assign bus.tx_en       = (state_q == SEND);
  assign bus.tx_data     = data_q;
  assign bus.grant       = grant_q;
  assign bus.err_timeout = err_q;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_spi_tx_arb.sv
// Random and directed traffic for spi_tx_arb, checked against a burst-order
// model of round-robin arbitration and an SPI master model.
module tb_spi_tx_arb;
  import spi_pkg::*;

  logic   clk = 1'b0;
  logic   rstn = 1'b0;
  state_t state_dbg;
  logic   m_busy = 1'b0;
  logic   ext_busy = 1'b0;
  bit     no_busy = 1'b0;
  bit     exp_err = 1'b0;
  bit     m_prio = 1'b0;
  int     total = 0;
  int     bad = 0;
  int     tx_cnt = 0;

  logic [9:0] exp_q[$];
  logic [7:0] bq0[$];
  logic [7:0] bq1[$];

  spi_tx_arb_if intf ();
  assign intf.spi_busy = m_busy | ext_busy;

  spi_tx_arb #(.BUSY_TO(64)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .bus       (intf),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: run did not finish, got timeout want summary");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic set_req(input int id, input logic v, input logic [7:0] d, input logic l);
    if (id == 0) begin
      intf.req0_valid = v; intf.req0_data = d; intf.req0_last = l;
    end else begin
      intf.req1_valid = v; intf.req1_data = d; intf.req1_last = l;
    end
  endtask

  function automatic logic ready_of(input int id);
    return (id == 0) ? intf.req0_ready : intf.req1_ready;
  endfunction

  // Offers n bytes from the requester's queue, one handshake each.
  task automatic drive_req(input int id, input int n, input bit last_en, input bit gaps);
    for (int i = 0; i < n; i++) begin
      logic [7:0] b;
      bit ok;
      b = (id == 0) ? bq0[i] : bq1[i];
      @(posedge clk); #1;
      set_req(id, 1'b1, b, last_en && (i == n - 1));
      ok = 1'b0;
      for (int c = 0; c < 3000; c++) begin
        @(negedge clk);
        if (ready_of(id)) begin ok = 1'b1; break; end
      end
      if (!ok) begin
        check("handshake_wait", 32'(ok), 32'd1);
        set_req(id, 1'b0, 8'h00, 1'b0);
        return;
      end
      @(posedge clk); #1;
      set_req(id, 1'b0, 8'h00, 1'b0);
      if (gaps) repeat ($urandom_range(0, 2)) @(posedge clk);
    end
  endtask

  task automatic push_burst(input int id, input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back({(id == 0) ? GRANT_REQ0 : GRANT_REQ1, (id == 0) ? bq0[i] : bq1[i]});
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !intf.spi_busy && state_dbg == IDLE) begin ok = 1'b1; break; end
    end
    check("drain_wait", 32'(ok), 32'd1);
  endtask

  // Whole bursts are served one at a time; on a tie the prio side goes first,
  // and prio ends up pointing away from whoever finished last.
  task automatic run_round(input bit s0, input bit s1, input int n0, input int n1,
                           input bit preset, input bit gaps);
    int first;
    int last_srv;
    if (!preset) begin
      bq0.delete(); bq1.delete();
      for (int i = 0; i < n0; i++) bq0.push_back(8'($urandom_range(0, 255)));
      for (int i = 0; i < n1; i++) bq1.push_back(8'($urandom_range(0, 255)));
    end
    first = (s0 && s1) ? int'(m_prio) : (s0 ? 0 : 1);
    push_burst(first, (first == 0) ? n0 : n1);
    last_srv = first;
    if (s0 && s1) begin
      last_srv = 1 - first;
      push_burst(last_srv, (last_srv == 0) ? n0 : n1);
    end
    m_prio = (last_srv == 0);
    fork
      begin if (s0) drive_req(0, n0, 1'b1, gaps); end
      begin if (s1) drive_req(1, n1, 1'b1, gaps); end
    join
    wait_idle();
  endtask

  // SPI master model: busy rises a little after each start pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (rstn && intf.tx_en && !no_busy) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        @(posedge clk); #1 m_busy = 1'b1;
        repeat ($urandom_range(1, 5)) @(posedge clk);
        #1 m_busy = 1'b0;
      end
    end
  end

  // Monitor: every start pulse is matched against the expected queue.
  initial begin
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (intf.tx_en) begin
          tx_cnt++;
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_tx_en: got data %0h want no transfer", intf.tx_data);
          end else begin
            logic [9:0] e;
            e = exp_q.pop_front();
            check("tx_beat", {22'd0, intf.grant, intf.tx_data}, {22'd0, e});
          end
        end
        if (intf.grant != GRANT_NONE)
          check("ready_lock", {30'd0, {intf.req1_ready, intf.req0_ready} & ~intf.grant}, 32'd0);
        if (intf.err_timeout && !exp_err)
          check("spurious_timeout", 32'(intf.err_timeout), 32'd0);
      end
    end
  end

  initial begin
    bit ok;
    int n;
    int base;
    set_req(0, 1'b1, 8'h55, 1'b1);
    set_req(1, 1'b1, 8'haa, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    check("rst_grant", 32'(intf.grant), 32'd0);
    check("rst_tx_en", 32'(intf.tx_en), 32'd0);
    check("rst_tx_data", 32'(intf.tx_data), 32'd0);
    check("rst_ready", {30'd0, intf.req1_ready, intf.req0_ready}, 32'd0);
    check("rst_err", 32'(intf.err_timeout), 32'd0);
    set_req(0, 1'b0, 8'h00, 1'b0);
    set_req(1, 1'b0, 8'h00, 1'b0);
    @(posedge clk); #1 rstn = 1'b1;

    // Burst lock straight after reset: req0 owns A1..A3 while req1 waits.
    bq0 = '{8'ha1, 8'ha2, 8'ha3};
    bq1 = '{8'h5b};
    run_round(1'b1, 1'b1, 3, 1, 1'b1, 1'b0);

    // Single byte with grant held until busy falls.
    bq0 = '{8'h01};
    exp_q.push_back({GRANT_REQ0, 8'h01});
    m_prio = 1'b1;
    fork
      drive_req(0, 1, 1'b1, 1'b0);
      begin
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin @(negedge clk); if (intf.spi_busy) begin ok = 1'b1; break; end end
        check("single_busy_seen", 32'(ok), 32'd1);
        for (int c = 0; c < 200; c++) begin @(negedge clk); if (!intf.spi_busy) break; end
        check("single_grant_held", 32'(intf.grant), 32'(GRANT_REQ0));
        @(negedge clk);
        check("single_grant_clear", 32'(intf.grant), 32'(GRANT_NONE));
      end
    join
    wait_idle();

    run_round(1'b1, 1'b1, 1, 1, 1'b0, 1'b0);

    // Timeout: the master never answers.
    bq0 = '{8'h77};
    exp_q.push_back({GRANT_REQ0, 8'h77});
    no_busy = 1'b1;
    exp_err = 1'b1;
    fork
      drive_req(0, 1, 1'b0, 1'b0);
      begin
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin @(negedge clk); if (intf.tx_en) begin ok = 1'b1; break; end end
        check("timeout_tx_seen", 32'(ok), 32'd1);
        n = 0;
        for (int c = 0; c < 200; c++) begin @(negedge clk); n++; if (intf.err_timeout) break; end
        check("timeout_cycles", 32'(n), 32'd65);
        check("timeout_grant", 32'(intf.grant), 32'(GRANT_NONE));
        @(negedge clk);
        check("timeout_pulse_len", 32'(intf.err_timeout), 32'd0);
      end
    join
    exp_err = 1'b0;
    no_busy = 1'b0;
    m_prio = 1'b1;
    wait_idle();
    run_round(1'b1, 1'b1, 1, 2, 1'b0, 1'b0);

    // External busy holds off a waiting requester.
    @(posedge clk); #1 ext_busy = 1'b1;
    bq1 = '{8'h3c};
    exp_q.push_back({GRANT_REQ1, 8'h3c});
    m_prio = 1'b0;
    fork
      drive_req(1, 1, 1'b1, 1'b0);
      begin
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          check("ext_busy_hold", {30'd0, intf.req1_ready, intf.tx_en}, 32'd0);
        end
        @(posedge clk); #1 ext_busy = 1'b0;
      end
    join
    wait_idle();

    for (int r = 0; r < 12; r++) begin
      int s;
      s = $urandom_range(1, 3);
      run_round(s[0], s[1], $urandom_range(1, 4), $urandom_range(1, 4), 1'b0, 1'b1);
    end

    // Reset while byte 2 of 3 is on the wire.
    bq0 = '{8'hc1, 8'hc2, 8'hc3};
    push_burst(0, 2);
    base = tx_cnt;
    drive_req(0, 2, 1'b0, 1'b0);
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (tx_cnt == base + 2 && intf.spi_busy) begin ok = 1'b1; break; end
    end
    check("rst_mid_reach", 32'(ok), 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("rst_mid_state", 32'(state_dbg), 32'(IDLE));
    check("rst_mid_grant", 32'(intf.grant), 32'd0);
    check("rst_mid_tx_en", 32'(intf.tx_en), 32'd0);
    check("rst_mid_tx_data", 32'(intf.tx_data), 32'd0);
    check("rst_mid_ready", {30'd0, intf.req1_ready, intf.req0_ready}, 32'd0);
    check("rst_mid_err", 32'(intf.err_timeout), 32'd0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    m_prio = 1'b0;
    repeat (40) @(negedge clk);
    check("rst_mid_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
